// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with target buffer; combinational lookup, posedge update.
// Optional BPU_PERF_EN macro adds saturating perf_updates / perf_mispredicts counters.
module branch_predictor #(
  parameter int BPU_ENTRIES    = 256,
  parameter int BPU_INDEX_BITS = 8,
  parameter int PC_WIDTH       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                predicted_taken,
  output logic [PC_WIDTH-1:0] predicted_target,
  input  logic                update_valid,
  input  logic [PC_WIDTH-1:0] update_pc,
  input  logic                update_taken,
  input  logic [PC_WIDTH-1:0] update_target,
  input  logic                update_mispredict,
  input  logic                flush_all
`ifdef BPU_PERF_EN
  ,
  output logic [31:0]         perf_updates,
  output logic [31:0]         perf_mispredicts
`endif
);

  typedef struct packed {
    logic [1:0]          counter;
    logic [PC_WIDTH-1:0] target;
    logic                valid;
  } bpu_entry_t;

  bpu_entry_t entries [BPU_ENTRIES];

  logic [BPU_INDEX_BITS-1:0] lookup_idx;
  logic [BPU_INDEX_BITS-1:0] update_idx;
  bpu_entry_t                lookup_entry;
  bpu_entry_t                update_entry;
  bpu_entry_t                update_next;

  // No tags: PC bits above the index alias onto the same entry.
  assign lookup_idx   = lookup_pc[BPU_INDEX_BITS+1:2];
  assign update_idx   = update_pc[BPU_INDEX_BITS+1:2];
  assign lookup_entry = entries[lookup_idx];
  assign update_entry = entries[update_idx];

  assign predicted_taken  = lookup_entry.valid & lookup_entry.counter[1];
  assign predicted_target = lookup_entry.valid ? lookup_entry.target : '0;

  always_comb begin
    update_next = update_entry;
    if (!update_entry.valid) begin
      // Allocate only on taken; a not-taken miss leaves the entry alone.
      if (update_taken) begin
        update_next.valid   = 1'b1;
        update_next.counter = 2'b10;
        update_next.target  = update_target;
      end
    end else if (update_taken) begin
      if (update_entry.counter != 2'b11) update_next.counter = update_entry.counter + 2'b01;
      update_next.target = update_target;
    end else begin
      if (update_entry.counter != 2'b00) update_next.counter = update_entry.counter - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BPU_ENTRIES; i++) entries[i] <= '0;
    end else if (flush_all) begin
      for (int i = 0; i < BPU_ENTRIES; i++) entries[i].valid <= 1'b0;
    end else if (update_valid) begin
      entries[update_idx] <= update_next;
    end
  end

`ifdef BPU_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_updates     <= '0;
      perf_mispredicts <= '0;
    end else if (update_valid && !flush_all) begin
      if (perf_updates != 32'hFFFF_FFFF) perf_updates <= perf_updates + 32'd1;
      if (update_mispredict && perf_mispredicts != 32'hFFFF_FFFF)
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

  logic unused_bits;
`ifdef BPU_PERF_EN
  assign unused_bits = ^{lookup_pc[1:0], lookup_pc[PC_WIDTH-1:BPU_INDEX_BITS+2],
                         update_pc[1:0], update_pc[PC_WIDTH-1:BPU_INDEX_BITS+2]};
`else
  assign unused_bits = ^{lookup_pc[1:0], lookup_pc[PC_WIDTH-1:BPU_INDEX_BITS+2],
                         update_pc[1:0], update_pc[PC_WIDTH-1:BPU_INDEX_BITS+2],
                         update_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (perf checks only when BPU_PERF_EN is defined).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        predicted_taken;
  logic [31:0] predicted_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic        flush_all;
`ifdef BPU_PERF_EN
  logic [31:0] perf_updates;
  logic [31:0] perf_mispredicts;
`endif

  int checks = 0;
  int errors = 0;
  int exp_updates = 0;
  int exp_mispredicts = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk               (clk),
    .rst               (rst),
    .lookup_pc         (lookup_pc),
    .predicted_taken   (predicted_taken),
    .predicted_target  (predicted_target),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
    .flush_all         (flush_all)
`ifdef BPU_PERF_EN
    ,
    .perf_updates      (perf_updates),
    .perf_mispredicts  (perf_mispredicts)
`endif
  );

  // One accepted update, applied at the next posedge; update_* go to X afterwards.
  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic mis);
    update_valid      = 1'b1;
    update_pc         = pc;
    update_taken      = tk;
    update_target     = tgt;
    update_mispredict = mis;
    @(posedge clk); #1;
    update_valid      = 1'b0;
    update_pc         = 'x;
    update_taken      = 1'bx;
    update_target     = 'x;
    update_mispredict = 1'bx;
    exp_updates++;
    if (mis) exp_mispredicts++;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_all = 1'b0; update_valid = 1'b0;
    update_pc = '0; update_taken = 1'b0; update_target = '0; update_mispredict = 1'b0;
    lookup_pc = 32'h0000_0100;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (predicted_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %0b want 0", predicted_taken); end
    checks++; if (predicted_target !== 32'h0) begin errors++; $display("FAIL reset_target: got %h want 0", predicted_target); end
    lookup_pc = 32'h0; #1;
    checks++; if (predicted_taken !== 1'b0) begin errors++; $display("FAIL reset_taken_idx0: got %0b want 0", predicted_taken); end
`ifdef BPU_PERF_EN
    checks++; if (perf_updates !== 32'h0) begin errors++; $display("FAIL reset_perf_updates: got %0d want 0", perf_updates); end
`endif
  endtask

  task automatic test_allocate();
    do_update(32'h100, 1'b1, 32'h200, 1'b0);
    lookup_pc = 32'h100; #1;
    checks++; if (predicted_taken !== 1'b1) begin errors++; $display("FAIL alloc_taken: got %0b want 1", predicted_taken); end
    checks++; if (predicted_target !== 32'h200) begin errors++; $display("FAIL alloc_target: got %h want 200", predicted_target); end
  endtask

  task automatic test_counter_down();
    do_update(32'h100, 1'b0, 32'hDEAD_0000, 1'b1);
    lookup_pc = 32'h100; #1;
    checks++; if (predicted_taken !== 1'b0) begin errors++; $display("FAIL down_01_taken: got %0b want 0", predicted_taken); end
    checks++; if (predicted_target !== 32'h200) begin errors++; $display("FAIL down_01_target: got %h want 200", predicted_target); end
    do_update(32'h100, 1'b0, 32'hDEAD_0000, 1'b0);
    do_update(32'h100, 1'b0, 32'hDEAD_0000, 1'b0);
    #1;
    checks++; if (predicted_target !== 32'h200) begin errors++; $display("FAIL down_00_valid: got %h want 200", predicted_target); end
    do_update(32'h100, 1'b1, 32'h200, 1'b0);
    #1;
    checks++; if (predicted_taken !== 1'b0) begin errors++; $display("FAIL up_from_00: got %0b want 0", predicted_taken); end
    do_update(32'h100, 1'b1, 32'h200, 1'b0);
    #1;
    checks++; if (predicted_taken !== 1'b1) begin errors++; $display("FAIL up_to_10: got %0b want 1", predicted_taken); end
  endtask

  task automatic test_counter_up();
    do_update(32'h100, 1'b1, 32'h240, 1'b0);
    do_update(32'h100, 1'b1, 32'h240, 1'b0);
    lookup_pc = 32'h100; #1;
    checks++; if (predicted_taken !== 1'b1) begin errors++; $display("FAIL sat_11_taken: got %0b want 1", predicted_taken); end
    checks++; if (predicted_target !== 32'h240) begin errors++; $display("FAIL sat_11_target: got %h want 240", predicted_target); end
    do_update(32'h100, 1'b0, 32'hDEAD_0000, 1'b1);
    #1;
    checks++; if (predicted_taken !== 1'b1) begin errors++; $display("FAIL sat_down_10: got %0b want 1", predicted_taken); end
    checks++; if (predicted_target !== 32'h240) begin errors++; $display("FAIL nt_keeps_target: got %h want 240", predicted_target); end
    do_update(32'h100, 1'b0, 32'hDEAD_0000, 1'b0);
    #1;
    checks++; if (predicted_taken !== 1'b0) begin errors++; $display("FAIL sat_down_01: got %0b want 0", predicted_taken); end
  endtask

  task automatic test_alias();
    do_update(32'h100, 1'b1, 32'h200, 1'b0);
    lookup_pc = 32'h500; #1;
    checks++; if (predicted_taken !== 1'b1) begin errors++; $display("FAIL alias_taken: got %0b want 1", predicted_taken); end
    checks++; if (predicted_target !== 32'h200) begin errors++; $display("FAIL alias_target: got %h want 200", predicted_target); end
    lookup_pc = 32'h104; #1;
    checks++; if (predicted_target !== 32'h0) begin errors++; $display("FAIL neighbour_target: got %h want 0", predicted_target); end
  endtask

  task automatic test_no_alloc();
    do_update(32'h180, 1'b0, 32'h999, 1'b0);
    lookup_pc = 32'h180; #1;
    checks++; if (predicted_target !== 32'h0) begin errors++; $display("FAIL no_alloc_nt: got %h want 0", predicted_target); end
    update_valid = 1'b0; update_pc = 32'h180; update_taken = 1'b1; update_target = 32'h777;
    @(posedge clk); #1;
    checks++; if (predicted_taken !== 1'b0) begin errors++; $display("FAIL ignore_invalid_update: got %0b want 0", predicted_taken); end
  endtask

  task automatic test_same_cycle();
    update_valid = 1'b1; update_pc = 32'h140; update_taken = 1'b1;
    update_target = 32'h800; update_mispredict = 1'b0;
    lookup_pc = 32'h140; #1;
    checks++; if (predicted_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_before: got %0b want 0", predicted_taken); end
    @(posedge clk); #1;
    update_valid = 1'b0;
    exp_updates++;
    checks++; if (predicted_taken !== 1'b1) begin errors++; $display("FAIL same_cycle_after: got %0b want 1", predicted_taken); end
    checks++; if (predicted_target !== 32'h800) begin errors++; $display("FAIL same_cycle_target: got %h want 800", predicted_target); end
  endtask

  task automatic test_flush();
    logic [31:0] pcs [3];
    pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h300;
    flush_all = 1'b1; update_valid = 1'b1; update_pc = 32'h300;
    update_taken = 1'b1; update_target = 32'h700; update_mispredict = 1'b1;
    @(posedge clk); #1;
    flush_all = 1'b0; update_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lookup_pc = pcs[i]; #1;
      checks++; if (predicted_taken !== 1'b0 || predicted_target !== 32'h0) begin
        errors++; $display("FAIL flush_pc_%h: got %0b/%h want 0/0", pcs[i], predicted_taken, predicted_target);
      end
    end
    do_update(32'h100, 1'b1, 32'h220, 1'b0);
    lookup_pc = 32'h100; #1;
    checks++; if (predicted_taken !== 1'b1 || predicted_target !== 32'h220) begin
      errors++; $display("FAIL realloc: got %0b/%h want 1/220", predicted_taken, predicted_target);
    end
    do_update(32'h100, 1'b0, 32'h0, 1'b0);
    #1;
    checks++; if (predicted_taken !== 1'b0) begin errors++; $display("FAIL realloc_counter_10: got %0b want 0", predicted_taken); end
  endtask

  task automatic test_perf();
`ifdef BPU_PERF_EN
    checks++; if (perf_updates !== 32'(exp_updates)) begin errors++; $display("FAIL perf_updates: got %0d want %0d", perf_updates, exp_updates); end
    checks++; if (perf_mispredicts !== 32'(exp_mispredicts)) begin errors++; $display("FAIL perf_mispredicts: got %0d want %0d", perf_mispredicts, exp_mispredicts); end
`endif
  endtask

  task automatic test_async_reset();
    do_update(32'h100, 1'b1, 32'h260, 1'b0);
    lookup_pc = 32'h100; #1;
    checks++; if (predicted_target !== 32'h260) begin errors++; $display("FAIL pre_reset_target: got %h want 260", predicted_target); end
    update_valid = 1'b1; update_pc = 32'h100; update_taken = 1'b1; update_target = 32'h900;
    #2 rst = 1'b1;
    #1;
    checks++; if (predicted_target !== 32'h0 || predicted_taken !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %0b/%h want 0/0", predicted_taken, predicted_target);
    end
    @(posedge clk); #1;
    rst = 1'b0; update_valid = 1'b0;
    #1;
    checks++; if (predicted_target !== 32'h0) begin errors++; $display("FAIL reset_drops_update: got %h want 0", predicted_target); end
`ifdef BPU_PERF_EN
    checks++; if (perf_updates !== 32'h0 || perf_mispredicts !== 32'h0) begin
      errors++; $display("FAIL perf_after_reset: got %0d/%0d want 0/0", perf_updates, perf_mispredicts);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter_down();
    test_counter_up();
    test_alias();
    test_no_alloc();
    test_same_cycle();
    test_flush();
    test_perf();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
